// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the two requester ports (CPU "c_*", DMA "d_*") and the RAM-side
// strobes/data of the RAM arbiter.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata stable and
// holds them until *_ack pulses for one cycle. *_rdata is valid while *_ack
// is high for a read. A req still high at the clock edge that ends the idle
// cycle after the ack is taken as a new access.
//
// Modports:
//   slave  - the arbiter: takes requests and RAM read data, drives acks,
//            read data and the RAM address/strobes/write data.
//   master - the environment (CPU, DMA and RAM) seen from the other side.
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    // CPU port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ack;
    // DMA port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    // RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_r;
    logic              ram_w;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_oe;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output ram_addr, ram_r, ram_w, ram_wdata, ram_oe,
        input  ram_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  ram_addr, ram_r, ram_w, ram_wdata, ram_oe,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port RAM between the CPU (port C) and a DMA/loader
// engine (port D). One byte access per req/ack handshake:
//   IDLE   : sample requests, pick a winner, latch owner/we/addr/wdata
//   ACCESS : one RAM strobe cycle; read data registered at its closing edge
//   DONE   : one-cycle ack to the owner
// Throughput is at most one access every three clocks.
//
// Parameters:
//   ADDR_W    - RAM address width
//   DATA_W    - RAM data width
//   FIXED_PRI - 0: round-robin on ties; 1: C always wins ties
// Ports:
//   clk      - clock, all state on posedge
//   rst      - asynchronous active-high reset; aborts any access in flight
//   bus      - requester and RAM signals (ram_arbiter_if.slave)
//   o_state  - current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic                clk,
    input  logic                rst,
    ram_arbiter_if.slave        bus,
    output logic [1:0]          o_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner_d;   // 1 = current access belongs to D
    logic              r_last_d;    // 1 = most recent grant went to D
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_any_req;
    logic              w_grant_d;
    logic              w_access;

    // Winner selection. On a tie in round-robin mode the port that was not
    // granted last wins; reset leaves r_last_d=1 so C wins the first tie.
    always_comb begin
        w_any_req = bus.c_req | bus.d_req;
        w_grant_d = 1'b0;
        if (bus.d_req && !bus.c_req) begin
            w_grant_d = 1'b1;
        end else if (bus.d_req && bus.c_req) begin
            w_grant_d = (FIXED_PRI == 0) ? !r_last_d : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_d <= w_grant_d;
                        r_last_d  <= w_grant_d;
                        r_we      <= w_grant_d ? bus.d_we    : bus.c_we;
                        r_addr    <= w_grant_d ? bus.d_addr  : bus.c_addr;
                        r_wdata   <= w_grant_d ? bus.d_wdata : bus.c_wdata;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Read data is captured on the same edge the strobe ends;
                    // writes leave both read-data registers untouched.
                    if (!r_we) begin
                        if (r_owner_d) begin
                            r_d_rdata <= bus.ram_rdata;
                        end else begin
                            r_c_rdata <= bus.ram_rdata;
                        end
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign w_access      = (r_state == ST_ACCESS);
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;
    assign bus.ram_r     = w_access & ~r_we;
    assign bus.ram_w     = w_access & r_we;
    assign bus.ram_oe    = w_access & r_we;

    assign bus.c_ack     = (r_state == ST_DONE) & ~r_owner_d;
    assign bus.d_ack     = (r_state == ST_DONE) & r_owner_d;
    assign bus.c_rdata   = r_c_rdata;
    assign bus.d_rdata   = r_d_rdata;

    assign o_state       = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Bench for ram_arbiter: dut0 is round-robin, dut1 is fixed-priority.
// Each DUT has a behavioural byte RAM attached. Inputs are driven and
// outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
    logic [1:0] state0;
    logic [1:0] state1;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRI(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .o_state(state0)
    );
    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRI(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .o_state(state1)
    );

    // ---------------- RAM models ----------------
    logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (bus0.ram_w) mem0[bus0.ram_addr] <= bus0.ram_wdata;
    always @(posedge clk) if (bus1.ram_w) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    assign bus0.ram_rdata = mem0[bus0.ram_addr];
    assign bus1.ram_rdata = mem1[bus1.ram_addr];

    // strobe exclusivity / ram_oe tracking over the whole run
    logic excl_bad = 1'b0;
    always @(negedge clk) begin
        if ((bus0.ram_r && bus0.ram_w) || (bus0.ram_oe !== bus0.ram_w) ||
            (bus1.ram_r && bus1.ram_w) || (bus1.ram_oe !== bus1.ram_w))
            excl_bad = 1'b1;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive0(input bit port_d, input bit req, input bit we,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (port_d) begin
            bus0.d_req = req; bus0.d_we = we; bus0.d_addr = addr; bus0.d_wdata = wdata;
        end else begin
            bus0.c_req = req; bus0.c_we = we; bus0.c_addr = addr; bus0.c_wdata = wdata;
        end
    endtask

    typedef struct {
        bit                port_d;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;  // owner's rdata after the access
    } vec_t;

    // One access on dut0, req dropped on the ack cycle. Returns during DONE.
    task automatic run_vec(input vec_t v);
        int                cyc;
        bit                got_ack;
        int                n_strobe;
        logic [ADDR_W-1:0] s_addr;
        logic              s_w, s_r, s_oe, other_ack;
        logic [DATA_W-1:0] rdata;
        cyc = 0; got_ack = 0; n_strobe = 0;
        s_addr = '0; s_w = 0; s_r = 0; s_oe = 0; other_ack = 0; rdata = '0;
        @(negedge clk);
        drive0(v.port_d, 1'b1, v.we, v.addr, v.wdata);
        while (!got_ack && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus0.ram_r || bus0.ram_w) begin
                n_strobe++;
                s_addr = bus0.ram_addr; s_w = bus0.ram_w; s_r = bus0.ram_r; s_oe = bus0.ram_oe;
            end
            if (v.port_d ? bus0.d_ack : bus0.c_ack) begin
                got_ack   = 1;
                other_ack = v.port_d ? bus0.c_ack : bus0.d_ack;
                rdata     = v.port_d ? bus0.d_rdata : bus0.c_rdata;
                drive0(v.port_d, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        if (!got_ack) drive0(v.port_d, 1'b0, v.we, v.addr, v.wdata);
        check("vec_ack_latency", cyc, 2);
        check("vec_strobe_count", n_strobe, 1);
        check("vec_ram_addr", s_addr, v.addr);
        check("vec_ram_w", s_w, v.we);
        check("vec_ram_r", s_r, !v.we);
        check("vec_ram_oe", s_oe, v.we);
        check("vec_other_ack", other_ack, 0);
        check("vec_rdata", rdata, v.exp_rdata);
    endtask

    vec_t vecs [11];

    // ---------------- test sequence ----------------
    initial begin
        int  n_g, c_n, d_n, c3_cyc, d_cyc, acks, writes;
        bit  grants [4];
        bit  abort_ack, both_ack, d_early;

        vecs[0]  = '{0, 1, 14'h0010, 8'hA5, 8'h00};
        vecs[1]  = '{0, 0, 14'h0010, 8'h00, 8'hA5};
        vecs[2]  = '{1, 1, 14'h3FFF, 8'h3C, 8'h00};
        vecs[3]  = '{1, 0, 14'h3FFF, 8'h00, 8'h3C};
        vecs[4]  = '{0, 0, 14'h3FFF, 8'h00, 8'h3C};
        vecs[5]  = '{0, 1, 14'h0010, 8'h5A, 8'h3C};
        vecs[6]  = '{1, 0, 14'h0010, 8'h00, 8'h5A};
        vecs[7]  = '{0, 1, 14'h2000, 8'h77, 8'h3C};
        vecs[8]  = '{1, 0, 14'h2000, 8'h00, 8'h77};
        vecs[9]  = '{0, 0, 14'h0001, 8'h00, 8'h11};
        vecs[10] = '{1, 0, 14'h0002, 8'h00, 8'h22};

        rst = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        drive0(1'b1, 1'b0, 1'b0, '0, '0);
        bus1.c_req = 0; bus1.c_we = 0; bus1.c_addr = '0; bus1.c_wdata = '0;
        bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_state", state0, 0);
        check("rst_strobes_acks", {bus0.ram_r, bus0.ram_w, bus0.ram_oe, bus0.c_ack, bus0.d_ack}, 0);
        check("rst_ram_addr", bus0.ram_addr, 0);
        check("rst_ram_wdata", bus0.ram_wdata, 0);
        check("rst_rdata", {bus0.c_rdata, bus0.d_rdata}, 0);
        rst = 1'b0;

        // reset in the middle of a C write
        @(negedge clk);
        drive0(1'b0, 1'b1, 1'b1, 14'h0040, 8'h99);
        @(negedge clk);
        check("abort_in_access", state0, 1);
        check("abort_ram_w_before", bus0.ram_w, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_ram_w_after", {bus0.ram_w, bus0.ram_oe}, 0);
        check("abort_state_idle", state0, 0);
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        abort_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus0.c_ack || bus0.d_ack) abort_ack = 1;
        end
        check("abort_no_ack", abort_ack, 0);
        check("abort_no_write", (mem0[14'h0040] === 8'h99), 0);

        // both requesting continuously, round-robin: C, D, C, D
        @(negedge clk);
        drive0(1'b0, 1'b1, 1'b1, 14'h0001, 8'h11);
        drive0(1'b1, 1'b1, 1'b1, 14'h0002, 8'h22);
        n_g = 0; both_ack = 0;
        for (int i = 0; i < 20 && n_g < 4; i++) begin
            @(negedge clk);
            if (bus0.c_ack && bus0.d_ack) both_ack = 1;
            if (bus0.c_ack || bus0.d_ack) begin
                grants[n_g] = bus0.d_ack;
                n_g++;
                if (n_g == 4) begin
                    drive0(1'b0, 1'b0, 1'b0, '0, '0);
                    drive0(1'b1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check("rr_grant_count", n_g, 4);
        check("rr_grant_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
        check("rr_single_ack", both_ack, 0);

        // fixed priority (dut1): C wins every time until it drops
        @(negedge clk);
        bus1.c_req = 1; bus1.c_we = 1; bus1.c_addr = 14'h0005; bus1.c_wdata = 8'h55;
        bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 14'h0006; bus1.d_wdata = 8'h66;
        c_n = 0; d_n = 0; c3_cyc = 0; d_cyc = 0; d_early = 0;
        for (int i = 1; i <= 30 && d_n == 0; i++) begin
            @(negedge clk);
            if (bus1.c_ack) begin
                c_n++;
                if (c_n == 3) begin bus1.c_req = 0; c3_cyc = i; end
            end
            if (bus1.d_ack) begin
                d_n++;
                d_cyc = i;
                if (c_n < 3) d_early = 1;
                bus1.d_req = 0;
            end
        end
        bus1.c_req = 0; bus1.d_req = 0;
        check("fp_c_grants", c_n, 3);
        check("fp_d_grants", d_n, 1);
        check("fp_d_starved", d_early, 0);
        check("fp_d_after_c", d_cyc - c3_cyc, 3);

        // table-driven single accesses on dut0
        foreach (vecs[i]) run_vec(vecs[i]);

        // req held through the first ack -> a second identical access
        @(negedge clk);
        drive0(1'b0, 1'b1, 1'b1, 14'h0100, 8'h11);
        acks = 0; writes = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus0.ram_w) writes++;
            if (bus0.c_ack) begin
                acks++;
                if (acks == 2) drive0(1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        check("held_acks", acks, 2);
        check("held_writes", writes, 2);

        // req dropped on the ack cycle -> exactly one access
        @(negedge clk);
        drive0(1'b0, 1'b1, 1'b1, 14'h0101, 8'h12);
        acks = 0; writes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus0.ram_w) writes++;
            if (bus0.c_ack) begin
                acks++;
                drive0(1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        check("drop_acks", acks, 1);
        check("drop_writes", writes, 1);

        // request inputs changed after latching must not affect the access
        @(negedge clk);
        drive0(1'b0, 1'b1, 1'b1, 14'h0200, 8'h44);
        @(negedge clk);
        check("latch_addr", bus0.ram_addr, 14'h0200);
        drive0(1'b0, 1'b1, 1'b1, 14'h0300, 8'hEE);
        @(negedge clk);
        check("latch_ack", bus0.c_ack, 1);
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        check("latch_mem", mem0[14'h0200], 8'h44);
        run_vec('{0, 0, 14'h0200, 8'h00, 8'h44});

        repeat (3) @(negedge clk);
        check("strobe_exclusive", excl_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
